// File: rtl/bowling_turn_timer_pkg.sv
// Shared encodings for the bowling turn timer: FSM state codes and the 4-bit seconds/frame type.
// Pure definitions plus two small helpers; no logic or timing of its own.
package bowling_turn_timer_pkg;

   localparam int SECS_W = 4;

   typedef logic [SECS_W-1:0] secs_t;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_AIM   = 3'd1;
   localparam logic [2:0] ST_ROLL  = 3'd2;
   localparam logic [2:0] ST_SCORE = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Saturating decrement: the seconds readout never wraps below zero.
   function automatic secs_t secs_dec(input secs_t s);
      return (s == '0) ? '0 : s - secs_t'(1);
   endfunction

   function automatic logic is_timed_phase(input logic [2:0] st);
      return (st == ST_AIM) || (st == ST_ROLL) || (st == ST_SCORE);
   endfunction

endpackage

// File: rtl/bowling_turn_timer_tick_prescaler.sv
// One-second prescaler: down-counter that pulses tick combinationally while at zero and running.
// reload restarts a full second; run low freezes the count.
module tick_prescaler #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic run,
   input  logic reload,
   output logic tick
);

   localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0] RELOAD_VAL = CW'(CLK_HZ - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // tick must not depend on reload: reload is derived from the FSM, which consumes tick.
   assign tick = run && (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (reload) begin
         cnt_d = RELOAD_VAL;
      end else if (run) begin
         cnt_d = (cnt_q == '0) ? RELOAD_VAL : cnt_q - CW'(1);
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         cnt_q <= RELOAD_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bowling_turn_timer.sv
// Per-frame bowling turn sequencer: aim countdown, roll window, score hold, over FRAMES frames.
// All outputs registered; transitions and pulses appear one edge after the causing input or tick.
module bowling_turn_timer
   import bowling_turn_timer_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int AIM_SECS   = 5,
   parameter int ROLL_SECS  = 3,
   parameter int SCORE_SECS = 2,
   parameter int FRAMES     = 10
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       throw_det,
   output logic [2:0] state,
   output logic [3:0] secs_left,
   output logic [3:0] frame,
   output logic       tick,
   output logic       aim_timeout,
   output logic       frame_done,
   output logic       game_over
);

   localparam secs_t AIM_LEN   = secs_t'(AIM_SECS);
   localparam secs_t ROLL_LEN  = secs_t'(ROLL_SECS);
   localparam secs_t SCORE_LEN = secs_t'(SCORE_SECS);
   localparam secs_t LAST_FRM  = secs_t'(FRAMES);

   logic [2:0] state_q, state_d;
   secs_t      secs_q, secs_d;
   secs_t      frame_q, frame_d;
   logic       tick_q, tick_d;
   logic       aim_timeout_q, aim_timeout_d;
   logic       frame_done_q, frame_done_d;
   logic       game_over_q, game_over_d;

   logic       sec_tick;
   logic       presc_run;
   logic       presc_reload;
   logic       expiry;

   assign presc_run    = is_timed_phase(state_q) && !pause;
   assign presc_reload = (state_d != state_q);
   assign expiry       = sec_tick && (secs_q == secs_t'(1));

   tick_prescaler #(
      .CLK_HZ (CLK_HZ)
   ) u_prescaler (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .run      (presc_run),
      .reload   (presc_reload),
      .tick     (sec_tick)
   );

   always_comb begin
      state_d       = state_q;
      secs_d        = secs_q;
      frame_d       = frame_q;
      tick_d        = sec_tick;
      aim_timeout_d = 1'b0;
      frame_done_d  = 1'b0;
      // While paused every input is dropped and nothing advances.
      if (!pause) begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_d = ST_AIM;
                  frame_d = secs_t'(1);
                  secs_d  = AIM_LEN;
               end
            end
            ST_AIM: begin
               if (throw_det) begin
                  state_d = ST_ROLL;
                  secs_d  = ROLL_LEN;
               end else if (expiry) begin
                  state_d       = ST_ROLL;
                  secs_d        = ROLL_LEN;
                  aim_timeout_d = 1'b1;
               end else if (sec_tick) begin
                  secs_d = secs_dec(secs_q);
               end
            end
            ST_ROLL: begin
               if (expiry) begin
                  state_d = ST_SCORE;
                  secs_d  = SCORE_LEN;
               end else if (sec_tick) begin
                  secs_d = secs_dec(secs_q);
               end
            end
            ST_SCORE: begin
               if (expiry) begin
                  frame_done_d = 1'b1;
                  if (frame_q == LAST_FRM) begin
                     state_d = ST_DONE;
                     secs_d  = '0;
                  end else begin
                     state_d = ST_AIM;
                     secs_d  = AIM_LEN;
                     frame_d = frame_q + secs_t'(1);
                  end
               end else if (sec_tick) begin
                  secs_d = secs_dec(secs_q);
               end
            end
            default: begin
               state_d = ST_IDLE;
               secs_d  = '0;
               frame_d = '0;
            end
         endcase
      end
      game_over_d = (state_d == ST_DONE);
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         secs_q        <= '0;
         frame_q       <= '0;
         tick_q        <= 1'b0;
         aim_timeout_q <= 1'b0;
         frame_done_q  <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         secs_q        <= secs_d;
         frame_q       <= frame_d;
         tick_q        <= tick_d;
         aim_timeout_q <= aim_timeout_d;
         frame_done_q  <= frame_done_d;
         game_over_q   <= game_over_d;
      end
   end

   assign state       = state_q;
   assign secs_left   = secs_q;
   assign frame       = frame_q;
   assign tick        = tick_q;
   assign aim_timeout = aim_timeout_q;
   assign frame_done  = frame_done_q;
   assign game_over   = game_over_q;

endmodule

// File: tb/tb_bowling_turn_timer.sv
// Self-checking bench for bowling_turn_timer: directed scenarios plus random stimulus
// against a phase/elapsed-cycle reference model.
module tb_bowling_turn_timer;

   localparam int CLK_HZ = 4;
   localparam int AIM    = 3;
   localparam int ROLL   = 2;
   localparam int SCORE  = 1;
   localparam int FRAMES = 2;

   logic CLOCK_50  = 1'b0;
   logic reset     = 1'b0;
   logic start     = 1'b0;
   logic pause     = 1'b0;
   logic throw_det = 1'b0;

   logic [2:0] state;
   logic [3:0] secs_left;
   logic [3:0] frame;
   logic       tick, aim_timeout, frame_done, game_over;
   logic [14:0] dut_vec;

   int checks = 0;
   int errors = 0;

   // Reference model: phase number, seconds remaining, frame, cycles run in this phase.
   int m_phase, m_secs, m_frame, m_cyc;
   bit m_tick, m_to, m_fd;

   bowling_turn_timer #(
      .CLK_HZ(CLK_HZ), .AIM_SECS(AIM), .ROLL_SECS(ROLL), .SCORE_SECS(SCORE), .FRAMES(FRAMES)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .pause(pause), .throw_det(throw_det),
      .state(state), .secs_left(secs_left), .frame(frame), .tick(tick),
      .aim_timeout(aim_timeout), .frame_done(frame_done), .game_over(game_over)
   );

   assign dut_vec = {state, secs_left, frame, tick, aim_timeout, frame_done, game_over};

   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic logic [14:0] exp_vec();
      return {3'(m_phase), 4'(m_secs), 4'(m_frame), m_tick, m_to, m_fd, (m_phase == 4)};
   endfunction

   function automatic void model_reset();
      m_phase = 0; m_secs = 0; m_frame = 0; m_cyc = 0;
      m_tick = 0; m_to = 0; m_fd = 0;
   endfunction

   function automatic void enter(input int p, input int s);
      m_phase = p; m_secs = s; m_cyc = 0;
   endfunction

   function automatic void model_step();
      bit tk;
      m_tick = 0; m_to = 0; m_fd = 0;
      if (reset) begin
         model_reset();
         return;
      end
      if (pause) return;
      if (m_phase == 0 || m_phase == 4) begin
         if (start) begin
            enter(1, AIM);
            m_frame = 1;
         end
         return;
      end
      m_cyc++;
      tk = (m_cyc % CLK_HZ) == 0;
      m_tick = tk;
      if (m_phase == 1 && throw_det) begin
         enter(2, ROLL);
      end else if (tk && m_secs == 1) begin
         case (m_phase)
            1: begin enter(2, ROLL); m_to = 1; end
            2: enter(3, SCORE);
            default: begin
               m_fd = 1;
               if (m_frame == FRAMES) enter(4, 0);
               else begin m_frame++; enter(1, AIM); end
            end
         endcase
      end else if (tk && m_secs > 0) begin
         m_secs--;
      end
   endfunction

   task automatic step();
      @(posedge CLOCK_50);
      model_step();
      #2;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #1;
      model_reset();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if (dut_vec !== 15'd0) begin
         errors++;
         $display("FAIL reset_async: got %h expected %h", dut_vec, 15'd0);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", dut_vec, exp_vec());
         end
      end
      reset = 1'b0;
      step();
      checks++;
      if (dut_vec !== 15'd0) begin
         errors++;
         $display("FAIL reset_idle: got %h expected %h", dut_vec, 15'd0);
      end
   endtask

   task automatic test_countdown();
      int ticks = 0;
      apply_reset();
      pulse_start();
      checks++;
      if ({state, frame, secs_left} !== {3'd1, 4'd1, 4'd3}) begin
         errors++;
         $display("FAIL start_aim: got %h expected %h", {state, frame, secs_left}, {3'd1, 4'd1, 4'd3});
      end
      for (int i = 1; i <= 12; i++) begin
         step();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL countdown_model c%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         if (tick) ticks++;
         if (i == 4 || i == 8) begin
            checks++;
            if (tick !== 1'b1 || secs_left !== 4'(3 - i / 4)) begin
               errors++;
               $display("FAIL countdown_secs c%0d: got tick=%b secs=%0d expected tick=1 secs=%0d",
                        i, tick, secs_left, 3 - i / 4);
            end
         end
      end
      checks++;
      if (ticks !== 3) begin
         errors++;
         $display("FAIL countdown_ticks: got %0d expected 3", ticks);
      end
   endtask

   task automatic test_aim_timeout();
      int to_cnt = 0;
      apply_reset();
      pulse_start();
      for (int i = 1; i <= 12; i++) begin
         step();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL timeout_model c%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         if (aim_timeout) to_cnt++;
      end
      checks++;
      if ({to_cnt[3:0], aim_timeout, state, secs_left} !== {4'd1, 1'b1, 3'd2, 4'd2}) begin
         errors++;
         $display("FAIL timeout_roll: got cnt=%0d to=%b st=%0d secs=%0d expected cnt=1 to=1 st=2 secs=2",
                  to_cnt, aim_timeout, state, secs_left);
      end
      step();
      checks++;
      if (aim_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_single: got %b expected 0", aim_timeout);
      end
   endtask

   task automatic test_throw_at_expiry();
      int to_cnt = 0;
      apply_reset();
      pulse_start();
      for (int i = 1; i <= 12; i++) begin
         throw_det = (i == 12);
         step();
         if (aim_timeout) to_cnt++;
      end
      throw_det = 1'b0;
      checks++;
      if ({state, secs_left, tick} !== {3'd2, 4'd2, 1'b1} || to_cnt != 0) begin
         errors++;
         $display("FAIL throw_wins: got st=%0d secs=%0d tick=%b to_cnt=%0d expected st=2 secs=2 tick=1 to_cnt=0",
                  state, secs_left, tick, to_cnt);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL throw_model: got %h expected %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_full_game();
      int fd_cnt = 0;
      apply_reset();
      pulse_start();
      for (int i = 1; i <= 60; i++) begin
         throw_det = ($urandom_range(0, 9) == 0);
         step();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL game_model c%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         if (frame_done) fd_cnt++;
      end
      throw_det = 1'b0;
      checks++;
      if (fd_cnt != 2 || {state, game_over, frame, secs_left} !== {3'd4, 1'b1, 4'd2, 4'd0}) begin
         errors++;
         $display("FAIL game_done: got fd=%0d st=%0d go=%b frame=%0d secs=%0d expected fd=2 st=4 go=1 frame=2 secs=0",
                  fd_cnt, state, game_over, frame, secs_left);
      end
   endtask

   task automatic test_pause();
      apply_reset();
      pulse_start();
      repeat (5) step();
      pause = 1'b1;
      for (int i = 0; i < 20; i++) begin
         throw_det = (i == 7);
         start     = (i == 12);
         step();
         checks++;
         if ({state, secs_left, tick} !== {3'd1, 4'd2, 1'b0} || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL pause_hold c%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
      pause = 1'b0; throw_det = 1'b0; start = 1'b0;
      step();
      step();
      checks++;
      if ({state, secs_left, tick} !== {3'd1, 4'd2, 1'b0}) begin
         errors++;
         $display("FAIL pause_resume_early: got st=%0d secs=%0d tick=%b expected st=1 secs=2 tick=0",
                  state, secs_left, tick);
      end
      step();
      checks++;
      if ({state, secs_left, tick} !== {3'd1, 4'd1, 1'b1}) begin
         errors++;
         $display("FAIL pause_resume_tick: got st=%0d secs=%0d tick=%b expected st=1 secs=1 tick=1",
                  state, secs_left, tick);
      end
   endtask

   task automatic test_reset_mid_roll();
      apply_reset();
      pulse_start();
      repeat (14) step();
      pulse_start();
      checks++;
      if ({state, secs_left} !== {3'd2, 4'd2} || dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL start_in_roll: got %h expected %h", dut_vec, exp_vec());
      end
      reset = 1'b1;
      #1;
      model_reset();
      checks++;
      if (dut_vec !== 15'd0) begin
         errors++;
         $display("FAIL reset_mid_roll: got %h expected %h", dut_vec, 15'd0);
      end
      step();
      reset = 1'b0;
      step();
      pulse_start();
      repeat (50) step();
      checks++;
      if ({state, game_over} !== {3'd4, 1'b1}) begin
         errors++;
         $display("FAIL reach_done: got st=%0d go=%b expected st=4 go=1", state, game_over);
      end
      pulse_start();
      checks++;
      if ({state, frame, secs_left, game_over} !== {3'd1, 4'd1, 4'd3, 1'b0}) begin
         errors++;
         $display("FAIL restart_from_done: got st=%0d frame=%0d secs=%0d go=%b expected st=1 frame=1 secs=3 go=0",
                  state, frame, secs_left, game_over);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         start     = ($urandom_range(0, 19) == 0);
         throw_det = ($urandom_range(0, 5) == 0);
         pause     = ($urandom_range(0, 9) < 2);
         if ($urandom_range(0, 199) == 0) begin
            reset = 1'b1;
            #1;
            model_reset();
         end else begin
            reset = 1'b0;
         end
         step();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL random c%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
      start = 1'b0; throw_det = 1'b0; pause = 1'b0; reset = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_countdown();
      test_aim_timeout();
      test_throw_at_expiry();
      test_full_game();
      test_pause();
      test_reset_mid_roll();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
